// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues one imem request at a time, presents the
// returned word at the IF/ID boundary with backpressure, and computes the next PC.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h00400000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_fault
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    instr_d   = instr_q;
    ifpc_d    = ifpc_q;
    pc_next   = pc;
    imem_req  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
        end else if (pc[1:0] != 2'b00) begin
          valid_d = 1'b1;
          fault_d = 1'b1;
          ifpc_d  = pc;
          instr_d = NOP_INSTR;
          state_d = S_HOLD;
        end else begin
          imem_req = 1'b1;
          ifpc_d   = pc;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) pc_next = redirect_target;
        // A redirect seen before or with the response makes that response stale.
        if (imem_rvalid) begin
          if (discard_q || redirect_valid) begin
            discard_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            fault_d = 1'b0;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          valid_d = 1'b0;
          fault_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_FETCH;
        end else if (id_ready) begin
          pc_next = pc + 32'd4;
          valid_d = 1'b0;
          fault_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    // The PC register has no enable, so it must see RESET_PC while reset is held.
    if (rst) begin
      pc_next  = RESET_PC;
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      ifpc_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      instr_q   <= instr_d;
      ifpc_q    <= ifpc_d;
    end
  end

  assign imem_addr = pc;
  assign if_valid  = valid_q;
  assign if_fault  = fault_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign if_pc4    = ifpc_q + 32'd4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch unit, PC register and instruction memory.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h00400000;
  localparam logic [31:0] NOP_INSTR = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_fault;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: "have" = instruction presented, "busy" = fetch in flight, "drop" = in-flight data stale.
  bit          m_have, m_busy, m_drop, m_fault;
  logic [31:0] m_instr, m_pc;
  // Memory: single pending response, returned lat cycles after the request.
  bit          mem_active;
  int          mem_due;
  int          lat = 1;
  logic [31:0] mem_data;
  // Expectations for the current cycle.
  logic [31:0] exp_pc_next, exp_instr, exp_pc;
  bit          exp_req, exp_valid, exp_fault;

  fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc4(if_pc4), .if_fault(if_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic model_reset();
    m_have = 0; m_busy = 0; m_drop = 0; m_fault = 0;
    m_instr = NOP_INSTR; m_pc = 32'h0;
  endtask

  // Apply this cycle's inputs at the falling edge and derive expectations.
  task automatic drive(input bit r, input bit redir, input logic [31:0] tgt, input bit rdy);
    @(negedge clk);
    rst = r; redirect_valid = redir; redirect_target = tgt; id_ready = rdy;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_active) begin
      mem_due--;
      if (mem_due == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data;
        mem_active  = 0;
      end
    end
    if (r) begin
      model_reset();
      pc = RESET_PC;
    end
    #1;
    if (r) begin
      exp_pc_next = RESET_PC; exp_req = 0;
    end else if (m_have) begin
      exp_req = 0;
      exp_pc_next = redir ? tgt : (rdy ? pc + 32'd4 : pc);
    end else if (m_busy) begin
      exp_req = 0;
      exp_pc_next = redir ? tgt : pc;
    end else begin
      exp_req = !redir && (pc[1:0] == 2'b00);
      exp_pc_next = redir ? tgt : pc;
    end
    exp_valid = m_have;
    exp_instr = m_have ? m_instr : NOP_INSTR;
    exp_pc    = m_pc;
    exp_fault = m_fault;
  endtask

  // Clock edge: advance the model, the PC register and the memory.
  task automatic advance();
    @(posedge clk);
    #1;
    if (rst) begin
      pc = RESET_PC;
    end else begin
      if (m_have) begin
        if (redirect_valid || id_ready) m_have = 0;
      end else if (m_busy) begin
        if (imem_rvalid) begin
          m_busy = 0;
          if (!(m_drop || redirect_valid)) begin
            m_have = 1; m_instr = imem_rdata; m_fault = 0;
          end
          m_drop = 0;
        end else if (redirect_valid) begin
          m_drop = 1;
        end
      end else if (!redirect_valid) begin
        m_pc = pc;
        if (pc[1:0] != 2'b00) begin
          m_have = 1; m_fault = 1; m_instr = NOP_INSTR;
        end else begin
          m_busy = 1;
        end
      end
      if (exp_req) begin
        mem_active = 1; mem_due = lat; mem_data = $urandom;
      end
      pc = exp_pc_next;
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 32'h0, 1);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    tests_run++; if (if_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b want 0", if_fault); end
    tests_run++; if (if_instr !== NOP_INSTR) begin tests_failed++; $display("FAIL reset_instr: got %h want %h", if_instr, NOP_INSTR); end
    tests_run++; if (if_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    tests_run++; if (pc_next !== RESET_PC) begin tests_failed++; $display("FAIL reset_pc_next: got %h want %h", pc_next, RESET_PC); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
    advance();
    drive(1, 0, 32'h0, 1);
    advance();
  endtask

  task automatic test_first_fetch();
    lat = 1;
    drive(0, 0, 32'h0, 1);
    tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %b want 1", imem_req); end
    tests_run++; if (imem_addr !== 32'h00400000) begin tests_failed++; $display("FAIL first_addr: got %h want 00400000", imem_addr); end
    tests_run++; if (pc_next !== 32'h00400000) begin tests_failed++; $display("FAIL first_pc_hold: got %h want 00400000", pc_next); end
    advance();
    drive(0, 0, 32'h0, 1);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL first_not_yet_valid: got %b want 0", if_valid); end
    advance();
    drive(0, 0, 32'h0, 1);
    tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL first_valid: got %b want 1", if_valid); end
    tests_run++; if (if_pc !== 32'h00400000) begin tests_failed++; $display("FAIL first_if_pc: got %h want 00400000", if_pc); end
    tests_run++; if (if_pc4 !== 32'h00400004) begin tests_failed++; $display("FAIL first_if_pc4: got %h want 00400004", if_pc4); end
    tests_run++; if (if_instr !== exp_instr) begin tests_failed++; $display("FAIL first_instr: got %h want %h", if_instr, exp_instr); end
    tests_run++; if (pc_next !== 32'h00400004) begin tests_failed++; $display("FAIL first_pc_next: got %h want 00400004", pc_next); end
    advance();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    drive(0, 0, 32'h0, 0);
    advance();
    drive(0, 0, 32'h0, 0);
    held = imem_rdata;
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 32'h0, 0);
      tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid[%0d]: got %b want 1", i, if_valid); end
      tests_run++; if (if_instr !== held) begin tests_failed++; $display("FAIL bp_instr[%0d]: got %h want %h", i, if_instr, held); end
      tests_run++; if (if_pc !== 32'h00400004) begin tests_failed++; $display("FAIL bp_if_pc[%0d]: got %h want 00400004", i, if_pc); end
      tests_run++; if (pc_next !== 32'h00400004) begin tests_failed++; $display("FAIL bp_pc_next[%0d]: got %h want 00400004", i, pc_next); end
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_req[%0d]: got %b want 0", i, imem_req); end
      advance();
    end
    drive(0, 0, 32'h0, 1);
    tests_run++; if (pc_next !== 32'h00400008) begin tests_failed++; $display("FAIL bp_accept_pc_next: got %h want 00400008", pc_next); end
    advance();
  endtask

  task automatic test_redirect_wait();
    bit seen = 0;
    lat = 4;
    drive(0, 0, 32'h0, 1);
    tests_run++; if (imem_addr !== 32'h00400008 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL rw_req: got req=%b addr=%h want req=1 addr=00400008", imem_req, imem_addr); end
    advance();
    drive(0, 1, 32'h00400100, 1);
    tests_run++; if (pc_next !== 32'h00400100) begin tests_failed++; $display("FAIL rw_pc_next: got %h want 00400100", pc_next); end
    advance();
    lat = 1;
    for (int i = 0; i < 8 && !seen; i++) begin
      drive(0, 0, 32'h0, 1);
      if (imem_req === 1'b1) begin
        seen = 1;
        tests_run++; if (imem_addr !== 32'h00400100) begin tests_failed++; $display("FAIL rw_new_addr: got %h want 00400100", imem_addr); end
      end else begin
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_discard[%0d]: got if_valid=%b want 0", i, if_valid); end
      end
      advance();
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL rw_refetch: got no request want request within 8 cycles"); end
    drive(0, 0, 32'h0, 0);
    advance();
  endtask

  task automatic test_redirect_flush();
    drive(0, 1, 32'h00400200, 1);
    tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL fl_pre_valid: got %b want 1", if_valid); end
    tests_run++; if (pc_next !== 32'h00400200) begin tests_failed++; $display("FAIL fl_pc_next: got %h want 00400200", pc_next); end
    advance();
    drive(0, 0, 32'h0, 0);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_flushed: got %b want 0", if_valid); end
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400200) begin tests_failed++; $display("FAIL fl_refetch: got req=%b addr=%h want req=1 addr=00400200", imem_req, imem_addr); end
    advance();
    drive(0, 0, 32'h0, 0);
    advance();
    drive(0, 0, 32'h0, 1);
    advance();
  endtask

  task automatic test_misaligned();
    drive(0, 1, 32'h00400002, 0);
    advance();
    drive(0, 0, 32'h0, 0);
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL mis_req: got %b want 0", imem_req); end
    advance();
    drive(0, 1, 32'hFFFFFFFC, 0);
    tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL mis_valid: got %b want 1", if_valid); end
    tests_run++; if (if_fault !== 1'b1) begin tests_failed++; $display("FAIL mis_fault: got %b want 1", if_fault); end
    tests_run++; if (if_instr !== NOP_INSTR) begin tests_failed++; $display("FAIL mis_instr: got %h want %h", if_instr, NOP_INSTR); end
    tests_run++; if (if_pc !== 32'h00400002) begin tests_failed++; $display("FAIL mis_if_pc: got %h want 00400002", if_pc); end
    advance();
  endtask

  task automatic test_wrap_reset();
    drive(0, 0, 32'h0, 1);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC) begin tests_failed++; $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
    advance();
    drive(0, 0, 32'h0, 1);
    advance();
    drive(0, 0, 32'h0, 1);
    tests_run++; if (if_pc4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc4: got %h want 00000000", if_pc4); end
    tests_run++; if (pc_next !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc_next: got %h want 00000000", pc_next); end
    advance();
    lat = 3;
    drive(0, 0, 32'h0, 1);
    advance();
    drive(1, 0, 32'h0, 1);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b want 0", if_valid); end
    tests_run++; if (pc_next !== RESET_PC) begin tests_failed++; $display("FAIL rst_mid_pc_next: got %h want %h", pc_next, RESET_PC); end
    advance();
    lat = 1;
    drive(0, 1, RESET_PC, 1);
    advance();
    drive(0, 1, RESET_PC, 1);
    advance();
    drive(0, 0, 32'h0, 1);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL late_rvalid: got if_valid=%b want 0", if_valid); end
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin tests_failed++; $display("FAIL post_rst_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC); end
    advance();
  endtask

  task automatic test_random();
    bit r, rd, rdy;
    logic [31:0] tgt;
    for (int n = 0; n < 600; n++) begin
      lat = $urandom_range(1, 4);
      r   = ($urandom_range(0, 99) < 2);
      rd  = ($urandom_range(0, 99) < 15);
      rdy = ($urandom_range(0, 99) < 60);
      tgt = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      drive(r, rd, tgt, rdy);
      tests_run++; if (pc_next !== exp_pc_next) begin tests_failed++; $display("FAIL rnd_pc_next@%0d: got %h want %h", n, pc_next, exp_pc_next); end
      tests_run++; if (imem_req !== exp_req) begin tests_failed++; $display("FAIL rnd_req@%0d: got %b want %b", n, imem_req, exp_req); end
      tests_run++; if (imem_addr !== pc) begin tests_failed++; $display("FAIL rnd_addr@%0d: got %h want %h", n, imem_addr, pc); end
      tests_run++; if (if_valid !== exp_valid) begin tests_failed++; $display("FAIL rnd_valid@%0d: got %b want %b", n, if_valid, exp_valid); end
      tests_run++; if (if_instr !== exp_instr) begin tests_failed++; $display("FAIL rnd_instr@%0d: got %h want %h", n, if_instr, exp_instr); end
      if (exp_valid) begin
        tests_run++; if (if_pc !== exp_pc) begin tests_failed++; $display("FAIL rnd_if_pc@%0d: got %h want %h", n, if_pc, exp_pc); end
        tests_run++; if (if_pc4 !== exp_pc + 32'd4) begin tests_failed++; $display("FAIL rnd_if_pc4@%0d: got %h want %h", n, if_pc4, exp_pc + 32'd4); end
        tests_run++; if (if_fault !== exp_fault) begin tests_failed++; $display("FAIL rnd_fault@%0d: got %b want %b", n, if_fault, exp_fault); end
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; pc = RESET_PC;
    redirect_valid = 1'b0; redirect_target = 32'h0; id_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    mem_active = 0; mem_due = 0; mem_data = 32'h0;
    model_reset();
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_flush();
    test_misaligned();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch controller for the pipelined CPU.
- It reads the current PC from the PC register, fetches one word from instruction memory over a request/response handshake, and presents the instruction to the IF/ID boundary with backpressure.
- It computes the PC register's next value every cycle: hold, pc+4, or redirect target. The PC register has no enable, so "hold" is produced here.

Parameters:
- RESET_PC, 32'h00400000, value driven on pc_next while rst is high; matches the PC register reset value.
- NOP_INSTR, 32'h00000000, value of if_instr whenever if_valid=0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc  in  32  current PC from PC register output
- pc_next  out  32  next PC to PC register data input (combinational)
- imem_req  out  1  fetch request strobe, single cycle
- imem_addr  out  32  fetch address, valid when imem_req=1
- imem_rvalid  in  1  response valid, at least 1 cycle after the request
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1
- redirect_valid  in  1  branch/jump/exception redirect from a later stage
- redirect_target  in  32  redirect address
- id_ready  in  1  decode can accept the instruction this cycle
- if_valid  out  1  instruction output valid (registered)
- if_instr  out  32  instruction (registered)
- if_pc  out  32  PC of if_instr (registered)
- if_pc4  out  32  if_pc+4, modulo 2^32
- if_fault  out  1  misaligned fetch; qualifies if_valid

Behaviour:
- Reset (async, rst=1):
  - state=S_FETCH, discard=0, if_valid=0, if_fault=0, if_instr=NOP_INSTR, if_pc=0.
  - pc_next=RESET_PC, imem_req=0.
  - Reset mid-transaction abandons the outstanding fetch. A late imem_rvalid after reset release is ignored because state is S_FETCH.
- Exactly one outstanding request at any time.
- States:
  - S_FETCH:
    - If redirect_valid: no request, pc_next=redirect_target, stay in S_FETCH.
    - Else if pc[1:0]!=0: no request. Load if_valid=1, if_fault=1, if_pc=pc, if_instr=NOP_INSTR. Go to S_HOLD.
    - Else: imem_req=1, imem_addr=pc, capture if_pc<=pc. Go to S_WAIT.
    - pc_next=pc in both non-redirect cases.
  - S_WAIT:
    - pc_next=pc, unless redirect_valid, in which case pc_next=redirect_target.
    - rvalid=1 and (discard=1 or redirect_valid=1): drop the data, discard<=0, go to S_FETCH.
    - rvalid=1 otherwise: if_instr<=imem_rdata, if_valid<=1, if_fault<=0, go to S_HOLD.
    - rvalid=0 and redirect_valid=1: discard<=1, stay in S_WAIT.
  - S_HOLD:
    - if_valid=1; outputs stable while id_ready=0.
    - redirect_valid=1, with or without id_ready: flush. pc_next=redirect_target, if_valid<=0, if_instr<=NOP_INSTR, go to S_FETCH.
    - id_ready=1 and no redirect: pc_next=pc+4 (wraps 32'hFFFFFFFC to 0), if_valid<=0, go to S_FETCH.
    - Otherwise pc_next=pc.
- Latency:
  - Request at cycle T, rvalid at T+k, if_valid at T+k+1.
  - Accept in S_HOLD at cycle A; the next request is at A+1 with the PC register already updated.
- if_pc4 is combinational from if_pc.
- A redirect target is never checked here; misalignment is caught on the next S_FETCH.

Test Plan:
- Release reset with pc=0x00400000, memory latency 1, id_ready=1 → imem_req at cycle 1 with addr 0x00400000. if_valid with if_pc=0x00400000 and if_pc4=0x00400004 at cycle 3. pc_next=0x00400004 in cycle 3.
- Backpressure: id_ready=0 for 5 cycles in S_HOLD → if_valid, if_instr and if_pc held stable. pc_next=pc throughout. No imem_req issued.
- Redirect while waiting: latency 4, redirect_valid to 0x00400100 one cycle after the request → pc_next=0x00400100 that cycle. The response is discarded with no if_valid. The next request uses addr 0x00400100.
- Redirect coincident with id_ready in S_HOLD → instruction flushed (if_valid=0 next cycle), pc_next=redirect_target, not pc+4.
- Misaligned pc=0x00400002 → no imem_req. if_valid=1, if_fault=1, if_instr=NOP_INSTR, if_pc=0x00400002.
- Wrap and reset: pc=0xFFFFFFFC accepted → pc_next=0x00000000. Assert rst during S_WAIT → if_valid=0 immediately. A late rvalid after release produces no output.
